bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Downstream consumer of the 3-digit BCD converter: captures a 12-bit BCD word via valid/ready and
//  time-multiplexes it onto one shared 7-segment bus with 3 digit enables. It performs leading-zero
//  blanking and flags non-BCD nibbles. Captures happen only at frame boundaries, so a frame never shows a torn value.
// PARAMETERS
//  SCAN_DIV        1000  clocks each digit is lit (>=2); counter width $clog2(SCAN_DIV)
//  SEG_ACTIVE_LOW  1     1: seg and dig_en driven inverted (common-anode); 0: active-high
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous reset, active-low (0 = reset)
//  bcd_in     in   12  [11:8] hundreds, [7:4] tens, [3:0] units
//  bcd_valid  in   1   bcd_in valid; upstream holds bcd_in stable until accepted
//  bcd_ready  out  1   block accepts bcd_in this cycle
//  seg        out  7   segments {g,f,e,d,c,b,a}
//  dig_en     out  3   [0] units, [1] tens, [2] hundreds
//  err        out  1   held value contains a nibble > 9
// BEHAVIOUR
//  - Reset (rst==0 at edge): state=IDLE, hold=12'h000, tick=0, err=0. Segments and digits are off
//    (logical 0; physical all-1 if SEG_ACTIVE_LOW). bcd_ready=1. Reset mid-frame aborts the frame and loses the held value.
//  - FSM: IDLE -> SCAN0 (units) -> SCAN1 (tens) -> SCAN2 (hundreds) -> SCAN0 ...
//  - IDLE: digits off, bcd_ready=1. On bcd_valid, capture and go to SCAN0; otherwise stay in IDLE.
//  - SCANn: tick counts 0..SCAN_DIV-1. Advance when tick==SCAN_DIV-1; tick clears on advance. A frame lasts 3*SCAN_DIV clocks.
//  - bcd_ready is 1 only in IDLE, or in SCAN2 with tick==SCAN_DIV-1 (one cycle per frame).
//  - Accept = bcd_valid & bcd_ready. hold<=bcd_in on the same edge. The new value is shown from the next SCAN0.
//  - If valid is absent at the boundary, the old hold is kept and scanning continues.
//  - bcd_valid while bcd_ready==0 is ignored; no capture happens and there is no error.
//  - err is registered on accept: 1 if any nibble of bcd_in >4'd9, else 0. It holds until the next accept.
//  - Outputs are a Moore function of (state, hold). There is no combinational path from bcd_in or bcd_valid to seg, dig_en or err.
//    bcd_ready depends only on state and tick.
//  - Exactly one dig_en bit is active in SCANn, except for blanked digits, which have dig_en=0 and seg=0.
//  - Blanking: hundreds blanked if hold[11:8]==0. Tens blanked if hold[11:4]==0. Units are never blanked.
//  - Decode (logical gfedcba):
//    0=0111111  1=0000110  2=1011011  3=1001111  4=1100110
//    5=1101101  6=1111101  7=0000111  8=1111111  9=1101111  10..15=1000000 (dash)
//  - A non-BCD nibble is never blanked. Example: 0x0A0 shows a dash in tens.
//  - SEG_ACTIVE_LOW inverts seg and dig_en at the output only; internal logic stays active-high.
// TESTING
//  T1 rst=0 for 2 clk -> dig_en=000, seg=0000000 (logical), bcd_ready=1, err=0. Hold rst=1 with no valid -> stays IDLE.
//  T2 SCAN_DIV=4, accept 0x255 -> next 4 clk dig_en=001 seg=1101101; then 4 clk 010 seg=1101101;
//     then 4 clk 100 seg=1011011. bcd_ready=1 only on the 12th cycle.
//  T3 accept 0x007 -> units shows 0000111. Tens and hundreds slots have dig_en=000, seg=0000000.
//     0x000 -> only units, seg=0111111.
//  T4 accept 0x1A3 -> err=1, tens seg=1000000, hundreds 0000110. Then accept 0x042 -> err=0,
//     hundreds blanked, tens 1100110.
//  T5 bcd_valid=1 with 0x999 asserted mid-SCAN1 -> no capture until the SCAN2 last-tick cycle; new digits appear from the next SCAN0.
//  T6 rst=0 during SCAN1 -> next edge IDLE, outputs off, hold=0. Re-accept 0x123 -> SCAN0 with units=1001111.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed 7-segment driver fed by a BCD word over valid/ready.
// New values are taken only between frames so a displayed frame is never torn.
module bcd_display_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] bcd_in,
   input  logic        bcd_valid,
   output logic        bcd_ready,
   output logic [6:0]  seg,
   output logic [2:0]  dig_en,
   output logic        err
);

   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, SCAN0, SCAN1, SCAN2} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] tick, tick_nxt;
   logic [11:0]   hold;
   logic          last_tick;
   logic          accept;
   logic [3:0]    nib;
   logic          blank;
   logic [2:0]    dig_log;
   logic [6:0]    seg_log;
   logic [2:0]    dig_act;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b1000000;
      endcase
      return s;
   endfunction

   assign last_tick = (tick == TICK_LAST);

   // Handshake: a transfer happens on any rising edge where bcd_valid && bcd_ready;
   // upstream keeps bcd_in stable while valid is high, ready never looks at valid.
   assign accept = bcd_valid & bcd_ready;

   always_comb begin
      state_nxt = state;
      tick_nxt  = tick;
      bcd_ready = 1'b0;
      case (state)
         IDLE: begin
            bcd_ready = 1'b1;
            tick_nxt  = '0;
            if (bcd_valid) state_nxt = SCAN0;
         end
         SCAN0: begin
            if (last_tick) begin
               state_nxt = SCAN1;
               tick_nxt  = '0;
            end else begin
               tick_nxt = tick + TW'(1);
            end
         end
         SCAN1: begin
            if (last_tick) begin
               state_nxt = SCAN2;
               tick_nxt  = '0;
            end else begin
               tick_nxt = tick + TW'(1);
            end
         end
         SCAN2: begin
            bcd_ready = last_tick;
            if (last_tick) begin
               state_nxt = SCAN0;
               tick_nxt  = '0;
            end else begin
               tick_nxt = tick + TW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            tick_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         tick  <= '0;
         hold  <= 12'h000;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         tick  <= tick_nxt;
         if (accept) begin
            hold <= bcd_in;
            err  <= (bcd_in[11:8] > 4'd9) | (bcd_in[7:4] > 4'd9) | (bcd_in[3:0] > 4'd9);
         end
      end
   end

   // Leading-zero blanking looks at the whole upper field, so a non-BCD nibble is never blanked.
   always_comb begin
      nib     = 4'h0;
      blank   = 1'b1;
      dig_log = 3'b000;
      case (state)
         SCAN0: begin
            nib     = hold[3:0];
            blank   = 1'b0;
            dig_log = 3'b001;
         end
         SCAN1: begin
            nib     = hold[7:4];
            blank   = (hold[11:4] == 8'h00);
            dig_log = 3'b010;
         end
         SCAN2: begin
            nib     = hold[11:8];
            blank   = (hold[11:8] == 4'h0);
            dig_log = 3'b100;
         end
         default: begin
            nib     = 4'h0;
            blank   = 1'b1;
            dig_log = 3'b000;
         end
      endcase
      seg_log = blank ? 7'b0000000 : seg_decode(nib);
      dig_act = blank ? 3'b000 : dig_log;
   end

   assign seg    = SEG_ACTIVE_LOW ? ~seg_log : seg_log;
   assign dig_en = SEG_ACTIVE_LOW ? ~dig_act : dig_act;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner: a driver queues values, a frame-level
// reference model consumes them at frame boundaries and checks every cycle.
module tb_bcd_display_scanner;

   localparam int D     = 4;
   localparam int FRAME = 3 * D;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] bcd_in = 12'h000;
   logic        bcd_valid = 1'b0;
   logic        bcd_ready;
   logic [6:0]  seg;
   logic [2:0]  dig_en;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [11:0] exp_q[$];

   bcd_display_scanner #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .bcd_in    (bcd_in),
      .bcd_valid (bcd_valid),
      .bcd_ready (bcd_ready),
      .seg       (seg),
      .dig_en    (dig_en),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b1000000;
      endcase
      return s;
   endfunction

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time since the last frame start plus the value shown in this frame.
   bit          m_active = 1'b0;
   int          m_phase  = 0;
   logic [11:0] m_shown  = 12'h000;
   logic        m_err    = 1'b0;

   initial begin
      bit          m_ready;
      int          slot;
      logic [11:0] upper;
      logic [6:0]  e_seg;
      logic [2:0]  e_dig;
      logic [6:0]  seg_l;
      logic [2:0]  dig_l;
      forever begin
         @(posedge clk);
         m_ready = !m_active || (m_phase == FRAME - 1);
         if (!rst) begin
            m_active = 1'b0;
            m_phase  = 0;
            m_shown  = 12'h000;
            m_err    = 1'b0;
         end else if (bcd_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL capture: accept with no queued value at %0t", $time);
            end else begin
               m_shown = exp_q.pop_front();
               m_err   = (m_shown[11:8] > 9) || (m_shown[7:4] > 9) || (m_shown[3:0] > 9);
            end
            m_active = 1'b1;
            m_phase  = 0;
         end else if (m_active) begin
            m_phase = (m_phase + 1) % FRAME;
         end
         #1;
         if (!m_active) begin
            e_seg   = 7'b0000000;
            e_dig   = 3'b000;
            m_ready = 1'b1;
         end else begin
            slot  = m_phase / D;
            upper = m_shown >> (4 * slot);
            if (slot > 0 && upper == 12'h000) begin
               e_seg = 7'b0000000;
               e_dig = 3'b000;
            end else begin
               e_seg = ref_seg(upper[3:0]);
               e_dig = 3'(1 << slot);
            end
            m_ready = (m_phase == FRAME - 1);
         end
         seg_l = ~seg;
         dig_l = ~dig_en;
         check("seg", 12'(seg_l), 12'(e_seg));
         check("dig_en", 12'(dig_l), 12'(e_dig));
         check("bcd_ready", 12'(bcd_ready), 12'(m_ready));
         check("err", 12'(err), 12'(m_err));
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [11:0] v);
      int n;
      @(negedge clk);
      bcd_in    = v;
      bcd_valid = 1'b1;
      exp_q.push_back(v);
      n = 0;
      while (!bcd_ready && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!bcd_ready) begin
         bad++;
         $display("FAIL handshake: value %0h not accepted within %0d cycles", v, 3 * FRAME);
         exp_q.delete();
         bcd_valid = 1'b0;
      end else begin
         @(negedge clk);
         bcd_valid = 1'b0;
         bcd_in    = 12'(($urandom_range(0, 4095)));
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [11:0] v;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      wait_cycles(5);

      send(12'h255);
      wait_cycles(2 * FRAME);
      send(12'h007);
      wait_cycles(FRAME + 2);
      send(12'h000);
      wait_cycles(FRAME);
      send(12'h1A3);
      wait_cycles(FRAME);
      send(12'h042);
      wait_cycles(D + 2);
      send(12'h999);
      wait_cycles(D + 1);
      pulse_reset();
      wait_cycles(3);
      send(12'h123);
      wait_cycles(FRAME);
      send(12'h0A0);
      send(12'hF00);
      wait_cycles(FRAME);

      for (int i = 0; i < 40; i++) begin
         wait_cycles($urandom_range(0, 2 * FRAME));
         case ($urandom_range(0, 3))
            0: v = 12'($urandom_range(0, 4095));
            1: v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            2: v = {8'h00, 4'($urandom_range(0, 15))};
            default: v = {4'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 9))};
         endcase
         if ($urandom_range(0, 9) == 0) pulse_reset();
         send(v);
      end

      wait_cycles(2 * FRAME);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
